// File: rtl/dmux16_stream.sv
// Purpose: routes a 16-bit upstream word to one of two registered output slots selected by in_sel.
// Latency: a word accepted on edge N is on outk_data/outk_valid right after edge N.
// Backpressure: in_ready drops only when the selected slot is full and its downstream is stalled.
module dmux16_stream (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out0_data,
    output logic        out0_valid,
    input  logic        out0_ready,
    output logic [15:0] out1_data,
    output logic        out1_valid,
    input  logic        out1_ready,
    output logic [7:0]  out0_count,
    output logic [7:0]  out1_count
);

    typedef struct packed {
        logic        vld;
        logic [15:0] dat;
    } slot_t;

    slot_t      slot_q [2];
    logic [7:0] cnt_q  [2];

    logic [1:0] dst_rdy;
    logic [1:0] acc_k;
    logic [1:0] dlv_k;
    logic       accept;

    assign dst_rdy = {out1_ready, out0_ready};

    // A full slot can still take a word in the cycle it drains, giving 1 word/cycle.
    always_comb begin
        in_ready = !reset && (!slot_q[in_sel].vld || dst_rdy[in_sel]);
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        acc_k = '0;
        dlv_k = '0;
        for (int k = 0; k < 2; k++) begin
            acc_k[k] = accept && (int'(in_sel) == k);
            dlv_k[k] = slot_q[k].vld && dst_rdy[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                slot_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                // Data is left in place on drain so an idle output shows the last word.
                if (acc_k[k]) begin
                    slot_q[k].vld <= 1'b1;
                    slot_q[k].dat <= in_data;
                end else if (dlv_k[k]) begin
                    slot_q[k].vld <= 1'b0;
                end
                if (dlv_k[k]) begin
                    cnt_q[k] <= cnt_q[k] + 8'd1;
                end
            end
        end
    end

    assign out0_valid = slot_q[0].vld;
    assign out0_data  = slot_q[0].dat;
    assign out1_valid = slot_q[1].vld;
    assign out1_data  = slot_q[1].dat;
    assign out0_count = cnt_q[0];
    assign out1_count = cnt_q[1];

endmodule

// File: doc/dmux16_stream.md
DMUX16_STREAM -- requirements
Module: dmux16_stream

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 in_data  input  16  upstream word.
REQ-004 in_sel  input  1  destination select; 0 -> out0, 1 -> out1.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 out0_data  output  16  registered word for destination 0.
REQ-008 out0_valid  output  1  out0_data holds an undelivered word.
REQ-009 out0_ready  input  1  downstream 0 accepts this cycle.
REQ-010 out1_data, out1_valid, out1_ready  output, output, input  16, 1, 1  same as REQ-007..009 for destination 1.
REQ-011 out0_count, out1_count  output  8  words delivered per destination, each modulo 256.

Function
REQ-012 Each destination k has one holding slot: slot_valid_k drives outk_valid; slot_data_k drives outk_data.
REQ-013 in_ready = !reset & (!slot_valid_s | outk_ready_s), where s = in_sel. This is combinational from in_sel, the slot state, the ready inputs and reset.
REQ-014 An accept occurs when in_valid & in_ready are high at a clock edge. A delivery on k occurs when outk_valid & outk_ready are high at a clock edge.
REQ-015 On accept into slot k: slot_data_k <= in_data and slot_valid_k <= 1.
REQ-016 On delivery on k with no accept into k: slot_valid_k <= 0 and slot_data_k holds its value.
REQ-017 Delivery and accept on the same k in the same cycle: the new word is loaded, slot_valid_k stays 1, and the old word counts as delivered. Full throughput is 1 word/cycle per destination.
REQ-018 Latency: a word accepted at edge N is visible on outk_data/outk_valid immediately after edge N. There is no combinational path from in_data to outk_data.
REQ-019 The destinations are independent. The unselected slot may deliver in the same cycle as an accept into the other slot. Its state is never altered by an accept that is not addressed to it.
REQ-020 Slot full and downstream not ready: in_ready = 0 for words addressed to that slot. Words addressed to the other slot are still accepted if that slot permits.
REQ-021 in_sel and in_data are sampled only on an accept. Upstream holds in_valid, in_sel and in_data stable until accepted. Behaviour is undefined if it does not.
REQ-022 outk_count increments by 1 on each delivery on k and wraps from 255 to 0.
REQ-023 When outk_valid = 0, outk_data holds the last loaded word, or 0 if no word has been loaded since reset.
REQ-024 There are no FSM states beyond the two slot_valid bits. The per-slot states are EMPTY and FULL:
- EMPTY -> FULL on accept.
- FULL -> EMPTY on delivery without accept.
- FULL -> FULL on accept, or when no delivery occurs.

Reset
REQ-025 While reset is high at an edge: slot_valid_0/1 <= 0, slot_data_0/1 <= 16'h0000, and out0_count/out1_count <= 8'h00. Reset overrides any concurrent accept or delivery.
REQ-026 in_ready = 0 throughout any cycle in which reset is high.
REQ-027 Reset asserted mid-operation discards buffered words without counting them as delivered.

Verification
REQ-028 Reset, then idle -> out0_valid = out1_valid = 0, out0_data = out1_data = 0, counts = 0, in_ready = 1.
REQ-029 Route: in_sel = 0 with in_data 16'h0001, then in_sel = 1 with 16'h0081, both ready inputs = 1 -> out0 = 16'h0001 for one cycle, then out1 = 16'h0081 for one cycle; each count = 1; out1_valid never asserted with 16'h0001.
REQ-030 Backpressure: out0_ready = 0, accept 16'hAAAA to out0, then present 16'hBBBB to out0 -> in_ready = 0 and out0_data stays 16'hAAAA. Raise out0_ready -> 16'hBBBB is accepted in the same cycle that 16'hAAAA is delivered; out0_count = 1, then 2 after the next delivery.
REQ-031 Independence: out0 slot full and stalled, then present 16'h1234 to out1 -> accepted immediately; out1_data = 16'h1234 the next cycle; out0 slot unchanged.
REQ-032 Wrap: stream 256 words to out1 with out1_ready = 1 -> out1_count returns to 8'h00; out0_count = 0; in_ready stays 1 continuously.
REQ-033 Reset mid-operation: both slots full, assert reset for one cycle with in_valid = 1 -> both valids = 0, counts = 0, no accept during the reset cycle.
